// File: rtl/window_gen_pkg.sv
// Shared types and helpers for window_generator and its line buffers.
package window_gen_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    // Column counter / line-buffer address width for a given line depth.
    function automatic int cnt_w(input int max_line_w);
        return (max_line_w > 2) ? $clog2(max_line_w) : 1;
    endfunction

endpackage

// File: rtl/window_generator_line_buffer.sv
// One line of pixel history: simple dual-port RAM with a registered read.
// A same-address write is forwarded so back-to-back one-pixel lines read fresh data.
module line_buffer
    import window_gen_pkg::*;
#(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 12,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/window_generator.sv
// Raster stream -> WINDOW_SIZE x WINDOW_SIZE interior windows, 2-cycle latency.
// Optional line-length checking is built when WINDOW_GEN_LEN_CHECK_EN is defined.
module window_generator
    import window_gen_pkg::*;
#(
    parameter int PIX_DATA_W    = 12,
    parameter int WINDOW_SIZE   = 3,
    parameter int MAX_LINE_W    = 2048,
    parameter int INPUTS_AMOUNT = WINDOW_SIZE * WINDOW_SIZE
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     data_valid_i,
    input  logic [PIX_DATA_W-1:0]                    data_i,
    input  logic                                     sof_i,
    input  logic                                     eol_i,
    output logic                                     data_valid_o,
    output logic [INPUTS_AMOUNT-1:0][PIX_DATA_W-1:0] data_o,
    output logic                                     len_err_o
);

    localparam int CW     = cnt_w(MAX_LINE_W);
    localparam int RW     = $clog2(WINDOW_SIZE);
    localparam int NB     = WINDOW_SIZE - 1;
    localparam int STAGES = 2;
    localparam logic [CW-1:0] COL_LAST  = CW'(MAX_LINE_W - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(WINDOW_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(WINDOW_SIZE - 1);

    state_t          state, state_nx, px_st;
    logic [CW-1:0]   col_cnt, col_nx, px_col;
    logic [RW-1:0]   row_cnt, row_nx, px_row;
    logic            ovf, ovf_nx, px_ovf;
    logic            px_acc, px_wr, px_win;

    logic [STAGES:1] vld_pipe;
    logic            wr_s1;
    logic [PIX_DATA_W-1:0] pix_s1;
    logic [CW-1:0]         addr_s1;
    logic [NB-1:0][PIX_DATA_W-1:0] rd, lb_wd;
    logic [WINDOW_SIZE-1:0][PIX_DATA_W-1:0] col_new;
    // win[r][c] packs to the same bit layout as data_o[r*WINDOW_SIZE+c]
    logic [WINDOW_SIZE-1:0][WINDOW_SIZE-1:0][PIX_DATA_W-1:0] win, win_nx;

    // sof_i restarts the frame on the very pixel that carries it
    always_comb begin
        px_acc = data_valid_i && (sof_i || state != IDLE);
        px_st  = sof_i ? FILL : state;
        px_col = sof_i ? '0 : col_cnt;
        px_row = sof_i ? '0 : row_cnt;
        px_ovf = sof_i ? 1'b0 : ovf;
        px_wr  = px_acc && !px_ovf;
        px_win = px_wr && (px_st == RUN) && (px_col >= COL_FIRST);

        state_nx = state;
        col_nx   = col_cnt;
        row_nx   = row_cnt;
        ovf_nx   = ovf;
        if (px_acc) begin
            if (eol_i) begin
                col_nx = '0;
                ovf_nx = 1'b0;
                row_nx = (px_row == ROW_LAST) ? px_row : px_row + 1'b1;
            end else begin
                row_nx = px_row;
                ovf_nx = px_ovf || (px_col == COL_LAST);
                col_nx = (px_col == COL_LAST) ? px_col : px_col + 1'b1;
            end
            state_nx = (row_nx == ROW_LAST) ? RUN : FILL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            col_cnt  <= '0;
            row_cnt  <= '0;
            ovf      <= 1'b0;
            vld_pipe <= '0;
            wr_s1    <= 1'b0;
            data_o   <= '0;
        end else begin
            state    <= state_nx;
            col_cnt  <= col_nx;
            row_cnt  <= row_nx;
            ovf      <= ovf_nx;
            vld_pipe <= {vld_pipe[STAGES-1:1], px_win};
            wr_s1    <= px_wr;
            if (vld_pipe[STAGES-1])
                data_o <= win_nx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (px_wr) begin
            pix_s1  <= data_i;
            addr_s1 <= px_col;
        end
        if (wr_s1)
            win <= win_nx;
    end

    assign data_valid_o = vld_pipe[STAGES];

    // Cascade: buffer k+1 takes what buffer k held for this column
    always_comb begin
        lb_wd[0] = pix_s1;
        for (int k = 1; k < NB; k++)
            lb_wd[k] = rd[k-1];
    end

    for (genvar k = 0; k < NB; k++) begin : g_lb
        line_buffer #(
            .DEPTH(MAX_LINE_W),
            .WIDTH(PIX_DATA_W),
            .AW   (CW)
        ) u_lb (
            .clk_i(clk_i),
            .we   (wr_s1),
            .waddr(addr_s1),
            .wdata(lb_wd[k]),
            .re   (px_wr),
            .raddr(px_col),
            .rdata(rd[k])
        );
    end

    always_comb begin
        col_new[WINDOW_SIZE-1] = pix_s1;
        for (int r = 0; r < WINDOW_SIZE - 1; r++)
            col_new[r] = rd[WINDOW_SIZE-2-r];
        for (int r = 0; r < WINDOW_SIZE; r++) begin
            for (int c = 0; c < WINDOW_SIZE - 1; c++)
                win_nx[r][c] = win[r][c+1];
            win_nx[r][WINDOW_SIZE-1] = col_new[r];
        end
    end

`ifdef WINDOW_GEN_LEN_CHECK_EN
    logic          first_line, err_s1, px_first, px_err;
    logic [CW-1:0] len_ref;

    // Lengths are compared as last-column index; overflowing lines always flag
    assign px_first = sof_i || first_line;
    assign px_err   = px_acc && eol_i && (px_ovf || (!px_first && px_col != len_ref));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            first_line <= 1'b0;
            len_ref    <= '0;
            err_s1     <= 1'b0;
            len_err_o  <= 1'b0;
        end else begin
            err_s1    <= px_err;
            len_err_o <= err_s1;
            if (px_acc) begin
                if (eol_i) begin
                    first_line <= 1'b0;
                    if (px_first)
                        len_ref <= px_col;
                end else if (sof_i) begin
                    first_line <= 1'b1;
                end
            end
        end
    end
`else
    assign len_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_window_generator.sv
// Self-checking bench for window_generator: image-level reference model plus
// a table of expected windows for the basic frame.
`timescale 1ns/1ps
module tb_window_generator;

    localparam int PW   = 12;
    localparam int WS   = 3;
    localparam int MAXW = 8;
    localparam int NA   = WS * WS;

    typedef logic [NA-1:0][PW-1:0] win_t;
    typedef struct { int cyc; win_t win; bit chk; } exp_t;
    typedef struct { int r; int c; logic [PW-1:0] tl; } vec_t;

    logic clk = 1'b0;
    logic rst_i, data_valid_i, sof_i, eol_i;
    logic [PW-1:0] data_i;
    logic data_valid_o, len_err_o;
    win_t data_o;

    window_generator #(
        .PIX_DATA_W(PW), .WINDOW_SIZE(WS), .MAX_LINE_W(MAXW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .data_valid_i(data_valid_i), .data_i(data_i),
        .sof_i(sof_i), .eol_i(eol_i), .data_valid_o(data_valid_o),
        .data_o(data_o), .len_err_o(len_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0, n_err_seen = 0;
    int rst_cyc = -10;
    bit chk_en = 0, cap_en = 0, hold_known = 1;
    win_t last_win = '0;
    exp_t exp_q[$];
    exp_t obs_q[$];
    int   err_q[$];
    int   pix_cyc [0:7][0:15];

    // Reference model: the current frame as an image with per-pixel validity
    logic [PW-1:0] img     [0:63][0:15];
    bit            img_vld [0:63][0:15];
    bit m_active = 0, m_first = 0;
    int m_row = 0, m_cnt = 0, m_first_len = 0;

`ifdef WINDOW_GEN_LEN_CHECK_EN
    localparam int LEN_ON = 1;
`else
    localparam int LEN_ON = 0;
`endif

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic check_win(input string name, input win_t got, input win_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic void model_pix(input logic [PW-1:0] d, input bit s, input bit e);
        exp_t x;
        if (s) begin
            m_active = 1; m_row = 0; m_cnt = 0; m_first = 1;
            for (int r = 0; r < 64; r++)
                for (int c = 0; c < 16; c++)
                    img_vld[r][c] = 0;
        end
        if (!m_active || m_row > 63) return;
        if (m_cnt < MAXW) begin
            img[m_row][m_cnt] = d;
            img_vld[m_row][m_cnt] = 1;
            if (m_row >= WS - 1 && m_cnt >= WS - 1) begin
                x.chk = 1;
                for (int r = 0; r < WS; r++)
                    for (int c = 0; c < WS; c++) begin
                        x.win[r*WS+c] = img[m_row-(WS-1)+r][m_cnt-(WS-1)+c];
                        if (!img_vld[m_row-(WS-1)+r][m_cnt-(WS-1)+c]) x.chk = 0;
                    end
                x.cyc = cyc + 2;
                exp_q.push_back(x);
            end
        end
        m_cnt++;
        if (e) begin
            if (LEN_ON != 0 && (m_cnt > MAXW || (!m_first && m_cnt != m_first_len)))
                err_q.push_back(cyc + 2);
            if (m_first) begin m_first_len = m_cnt; m_first = 0; end
            m_row++;
            m_cnt = 0;
        end
    endfunction

    always @(negedge clk) if (chk_en) begin
        if (cyc == rst_cyc + 1) begin last_win = '0; hold_known = 1; end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_tests++; n_fail++;
            $display("FAIL missing_window: expected at cyc %0d got none, want %h", exp_q[0].cyc, exp_q[0].win);
            exp_q.delete(0);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            check_int("window_valid", int'(data_valid_o), 1);
            if (exp_q[0].chk) begin
                check_win("window_data", data_o, exp_q[0].win);
                last_win = exp_q[0].win;
                hold_known = 1;
            end else begin
                hold_known = 0;
            end
            exp_q.delete(0);
        end else begin
            check_int("no_window", int'(data_valid_o), 0);
            if (hold_known) check_win("data_hold", data_o, last_win);
        end
        if (cap_en && data_valid_o) begin
            exp_t o;
            o.cyc = cyc; o.win = data_o; o.chk = 1;
            obs_q.push_back(o);
        end
        while (err_q.size() > 0 && err_q[0] < cyc) begin
            n_tests++; n_fail++;
            $display("FAIL missing_len_err: expected at cyc %0d got none", err_q[0]);
            err_q.delete(0);
        end
        if (err_q.size() > 0 && err_q[0] == cyc) begin
            check_int("len_err_pulse", int'(len_err_o), 1);
            err_q.delete(0);
        end else begin
            check_int("len_err_idle", int'(len_err_o), 0);
        end
        if (len_err_o) n_err_seen++;
    end

    task automatic drive(input bit v, input logic [PW-1:0] d, input bit s, input bit e);
        @(posedge clk); #1;
        data_valid_i = v; data_i = d; sof_i = s; eol_i = e;
        if (v) model_pix(d, s, e);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, '0, 0, 0);
    endtask

    // One line of w pixels; rnd selects random data, else base + r*16 + c
    task automatic send_line(input int w, input int r, input bit first, input int base,
                             input int max_gap, input bit rnd);
        logic [PW-1:0] d;
        for (int c = 0; c < w; c++) begin
            d = rnd ? PW'($urandom) : PW'(base + r * 16 + c);
            drive(1, d, first && c == 0, c == w - 1);
            if (r < 8 && c < 16) pix_cyc[r][c] = cyc;
            if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
        end
    endtask

    task automatic send_frame(input int w, input int h, input int base,
                              input int max_gap, input bit rnd);
        for (int r = 0; r < h; r++)
            send_line(w, r, r == 0, base, max_gap, rnd);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_i = 1; data_valid_i = 0; sof_i = 0; eol_i = 0;
        rst_cyc = cyc;
        m_active = 0;
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].cyc > cyc) exp_q.delete(i);
        for (int i = err_q.size() - 1; i >= 0; i--)
            if (err_q[i] > cyc) err_q.delete(i);
        @(posedge clk); #1;
        rst_i = 0;
        @(negedge clk);
        check_int("rst_mid_valid", int'(data_valid_o), 0);
        check_win("rst_mid_data", data_o, '0);
        check_int("rst_mid_len_err", int'(len_err_o), 0);
    endtask

    initial begin
        vec_t tbl [6];
        win_t ew;
        int e0;
        int lens [4];

        // Basic 5-wide x 4-high frame: completing pixel and window top-left value
        tbl[0] = '{2, 2, 12'h000};
        tbl[1] = '{2, 3, 12'h001};
        tbl[2] = '{2, 4, 12'h002};
        tbl[3] = '{3, 2, 12'h010};
        tbl[4] = '{3, 3, 12'h011};
        tbl[5] = '{3, 4, 12'h012};

        rst_i = 1; data_valid_i = 0; data_i = '0; sof_i = 0; eol_i = 0;
        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        @(negedge clk);
        check_int("reset_valid", int'(data_valid_o), 0);
        check_win("reset_data", data_o, '0);
        check_int("reset_len_err", int'(len_err_o), 0);
        chk_en = 1;

        // Pixels before any sof_i are dropped
        send_line(4, 0, 0, 12'h700, 0, 0);
        idle(3);

        // Basic frame, continuous valid, table-checked
        cap_en = 1;
        send_frame(5, 4, 0, 0, 0);
        idle(4);
        cap_en = 0;
        check_int("basic_count", obs_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < WS; i++)
                for (int j = 0; j < WS; j++)
                    ew[i*WS+j] = tbl[k].tl + PW'(i * 16 + j);
            if (k < obs_q.size()) begin
                check_win("basic_window", obs_q[k].win, ew);
                check_int("basic_latency", obs_q[k].cyc, pix_cyc[tbl[k].r][tbl[k].c] + 2);
            end
        end

        // Same frame with random gaps, then random frames
        send_frame(5, 4, 0, 3, 0);
        idle(4);
        for (int f = 0; f < 6; f++) begin
            send_frame(int'($urandom_range(MAXW, 3)), int'($urandom_range(6, 3)), 0, 2, 1);
            idle(int'($urandom_range(3, 0)));
        end
        idle(4);

        // Restart mid-frame at row 3
        send_frame(5, 3, 12'h100, 0, 0);
        send_line(2, 3, 0, 12'h100, 0, 0);
        send_frame(5, 4, 12'h400, 1, 0);
        idle(4);

        // One-pixel line: sof_i and eol_i together
        drive(1, 12'h5a5, 1, 1);
        idle(4);

        // Overlong lines: 10 pixels against an 8-deep line buffer
        e0 = n_err_seen;
        send_frame(10, 4, 12'h200, 0, 0);
        idle(4);
        check_int("overlong_err_count", n_err_seen - e0, 4 * LEN_ON);

        // Reset during row 2 with windows in flight
        send_frame(5, 2, 12'h300, 0, 0);
        send_line(4, 2, 0, 12'h300, 0, 0);
        pulse_reset();
        send_line(5, 0, 0, 12'h600, 0, 0);
        idle(3);
        send_frame(5, 4, 12'h500, 1, 0);
        idle(4);

        // Line-length mismatch: 6,6,5,6
        lens = '{6, 6, 5, 6};
        e0 = n_err_seen;
        for (int r = 0; r < 4; r++)
            send_line(lens[r], r, r == 0, 12'h800, 0, 0);
        idle(4);
        check_int("len_mismatch_err_count", n_err_seen - e0, LEN_ON);

        idle(6);
        check_int("queues_drained", exp_q.size() + err_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
